gpio_fifo_ctrl: RTL and testbench

GPIO_FIFO_CTRL -- requirements
Module: gpio_fifo_ctrl

---
 rtl/gpio_fifo_ctrl.sv | 135 +++++++++++++
 tb/tb_gpio_fifo_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_fifo_ctrl.sv
// GPIO controller: paced TX FIFO driving registered pad outputs, and an RX FIFO
// that records synchronized input-pin snapshots whenever an input pin changes.
module gpio_fifo_ctrl #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int PERIOD_W    = 8
) (
    input  logic                   wclk,
    input  logic                   rrst_n,
    input  logic [WIDTH-1:0]       tx_wdata,
    input  logic                   tx_winc,
    output logic                   tx_wfull,
    output logic [$clog2(DEPTH):0] tx_count,
    input  logic [PERIOD_W-1:0]    out_period,
    input  logic [WIDTH-1:0]       dir,
    input  logic [WIDTH-1:0]       gpio_in,
    output logic [WIDTH-1:0]       gpio_out,
    output logic [WIDTH-1:0]       gpio_oe,
    output logic [WIDTH-1:0]       rx_rdata,
    input  logic                   rx_rinc,
    output logic                   rx_rempty,
    output logic [$clog2(DEPTH):0] rx_count,
    output logic [1:0]             ovf_status,
    input  logic                   ovf_clr,
    input  logic                   irq_en,
    output logic                   irq
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]         PTR_ONE  = 1;
    localparam logic [PERIOD_W-1:0] PACE_ONE = 1;

    // TX FIFO and output pacing
    logic [WIDTH-1:0]    tx_mem [DEPTH];
    logic [AW:0]         tx_wptr, tx_rptr;
    logic [PERIOD_W-1:0] pace;
    logic                tx_empty, tx_push, tx_pop;

    // Input synchronizer and RX FIFO
    logic [WIDTH-1:0] sync_ff [SYNC_STAGES];
    logic [WIDTH-1:0] sync_in, prev_in, change;
    logic [WIDTH-1:0] rx_mem [DEPTH];
    logic [AW:0]      rx_wptr, rx_rptr;
    logic             rx_full, rx_cap, rx_push, rx_pop;
    logic [1:0]       ovf_set;

    always_comb begin
        tx_empty = (tx_wptr == tx_rptr);
        tx_wfull = (tx_wptr[AW] != tx_rptr[AW]) && (tx_wptr[AW-1:0] == tx_rptr[AW-1:0]);
        tx_count = tx_wptr - tx_rptr;
        tx_push  = tx_winc && !tx_wfull;
        tx_pop   = (pace == '0) && !tx_empty;
    end

    always_ff @(posedge wclk) begin
        if (tx_push)
            tx_mem[tx_wptr[AW-1:0]] <= tx_wdata;
    end

    // Counter reloads only on a pop and otherwise drains to 0 and parks there,
    // so a word arriving in an idle FIFO leaves on the very next edge.
    always_ff @(posedge wclk or negedge rrst_n) begin
        if (!rrst_n) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            pace     <= '0;
            gpio_out <= '0;
            gpio_oe  <= '0;
        end else begin
            gpio_oe <= dir;
            if (tx_push)
                tx_wptr <= tx_wptr + PTR_ONE;
            if (tx_pop) begin
                tx_rptr  <= tx_rptr + PTR_ONE;
                pace     <= out_period;
                gpio_out <= tx_mem[tx_rptr[AW-1:0]];
            end else if (pace != '0) begin
                pace <= pace - PACE_ONE;
            end
        end
    end

    always_ff @(posedge wclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++)
                sync_ff[i] <= '0;
            prev_in <= '0;
        end else begin
            sync_ff[0] <= gpio_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++)
                sync_ff[i] <= sync_ff[i-1];
            prev_in <= sync_in;
        end
    end

    always_comb begin
        sync_in   = sync_ff[SYNC_STAGES-1];
        change    = (sync_in ^ prev_in) & ~dir;
        rx_rempty = (rx_wptr == rx_rptr);
        rx_full   = (rx_wptr[AW] != rx_rptr[AW]) && (rx_wptr[AW-1:0] == rx_rptr[AW-1:0]);
        rx_count  = rx_wptr - rx_rptr;
        rx_rdata  = rx_mem[rx_rptr[AW-1:0]];
        rx_cap    = |change;
        // Fullness is judged before the edge: a same-cycle pop never frees a slot.
        rx_push   = rx_cap && !rx_full;
        rx_pop    = rx_rinc && !rx_rempty;
        ovf_set   = {rx_cap && rx_full, tx_winc && tx_wfull};
    end

    always_ff @(posedge wclk) begin
        if (rx_push)
            rx_mem[rx_wptr[AW-1:0]] <= sync_in;
    end

    always_ff @(posedge wclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rx_wptr    <= '0;
            rx_rptr    <= '0;
            ovf_status <= '0;
            irq        <= 1'b0;
        end else begin
            if (rx_push)
                rx_wptr <= rx_wptr + PTR_ONE;
            if (rx_pop)
                rx_rptr <= rx_rptr + PTR_ONE;
            if (ovf_clr)
                ovf_status <= '0;
            else
                ovf_status <= ovf_status | ovf_set;
            irq <= irq_en && (!rx_rempty || (ovf_status != '0));
        end
    end

endmodule

// File: tb/tb_gpio_fifo_ctrl.sv
// Scoreboard bench for gpio_fifo_ctrl: stimulus queues expected pin words and RX
// words; a monitor compares them as the DUT presents them.
module tb_gpio_fifo_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int SYNC  = 2;
    localparam int PW    = 8;

    logic             wclk;
    logic             rrst_n;
    logic [WIDTH-1:0] tx_wdata;
    logic             tx_winc;
    logic             tx_wfull;
    logic [4:0]       tx_count;
    logic [PW-1:0]    out_period;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] gpio_in;
    logic [WIDTH-1:0] gpio_out;
    logic [WIDTH-1:0] gpio_oe;
    logic [WIDTH-1:0] rx_rdata;
    logic             rx_rinc;
    logic             rx_rempty;
    logic [4:0]       rx_count;
    logic [1:0]       ovf_status;
    logic             ovf_clr;
    logic             irq_en;
    logic             irq;

    gpio_fifo_ctrl #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SYNC), .PERIOD_W(PW)
    ) dut (
        .wclk(wclk), .rrst_n(rrst_n),
        .tx_wdata(tx_wdata), .tx_winc(tx_winc), .tx_wfull(tx_wfull), .tx_count(tx_count),
        .out_period(out_period), .dir(dir), .gpio_in(gpio_in),
        .gpio_out(gpio_out), .gpio_oe(gpio_oe),
        .rx_rdata(rx_rdata), .rx_rinc(rx_rinc), .rx_rempty(rx_rempty), .rx_count(rx_count),
        .ovf_status(ovf_status), .ovf_clr(ovf_clr), .irq_en(irq_en), .irq(irq)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct {
        logic [7:0] data;
        int         gap;   // cycles since previous pin change; 0 = not checked
    } tx_exp_t;

    tx_exp_t    tx_q[$];
    logic [7:0] rx_q[$];
    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge wclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pin-word changes and RX pops are checked against the queues.
    initial begin : monitor
        logic [7:0] last_out;
        int         last_cyc;
        tx_exp_t    e;
        logic [7:0] r;
        last_out = '0;
        last_cyc = 0;
        forever begin
            @(negedge wclk);
            if (!rrst_n) begin
                last_out = gpio_out;
            end else begin
                if (rx_rinc && !rx_rempty) begin
                    if (rx_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL rx_unexpected: got 0x%0h, expected no RX word", rx_rdata);
                    end else begin
                        r = rx_q.pop_front();
                        check("rx_data", rx_rdata, r);
                    end
                end
                if (gpio_out !== last_out) begin
                    if (tx_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL tx_unexpected: got 0x%0h, expected no pin change", gpio_out);
                    end else begin
                        e = tx_q.pop_front();
                        check("tx_pin", gpio_out, e.data);
                        if (e.gap != 0)
                            check("tx_gap", cyc - last_cyc, e.gap);
                    end
                    last_out = gpio_out;
                    last_cyc = cyc;
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge wclk);
            #1;
        end
    endtask

    // gap < 0: word is accepted but never expected on the pins in this run
    task automatic push_tx(input logic [7:0] d, input int gap);
        tx_winc  = 1'b1;
        tx_wdata = d;
        if (gap >= 0)
            tx_q.push_back('{data: d, gap: gap});
        tick();
        tx_winc = 1'b0;
    endtask

    task automatic wait_tx_empty(input int maxc);
        int k;
        k = 0;
        while (tx_count != 0 && k < maxc) begin
            tick();
            k++;
        end
        check("tx_drain", tx_count, 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_tx_count"}, tx_count, 0);
        check({tag, "_rx_count"}, rx_count, 0);
        check({tag, "_rx_rempty"}, rx_rempty, 1);
        check({tag, "_tx_wfull"}, tx_wfull, 0);
        check({tag, "_gpio_out"}, gpio_out, 0);
        check({tag, "_gpio_oe"}, gpio_oe, 0);
        check({tag, "_ovf"}, ovf_status, 0);
        check({tag, "_irq"}, irq, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rrst_n = 1'b0; tx_winc = 1'b0; tx_wdata = '0; out_period = '0;
        dir = 8'hF0; gpio_in = '0; rx_rinc = 1'b0; ovf_clr = 1'b0; irq_en = 1'b0;
        #1;
        check_reset_state("por");
        tick(2);
        rrst_n = 1'b1;
        tick();
        check("gpio_oe_dir", gpio_oe, 8'hF0);

        // Back-to-back words at period 0 reach the pins on consecutive cycles
        out_period = 8'd0;
        push_tx(8'hA5, 0);
        check("p0_count1", tx_count, 1);
        push_tx(8'h3C, 1);
        check("p0_push_pop_count", tx_count, 1);
        tick();
        check("p0_count0", tx_count, 0);
        check("p0_last", gpio_out, 8'h3C);

        // Period 3: one pin update every 4 cycles
        out_period = 8'd3;
        push_tx(8'h41, 0);
        push_tx(8'h42, 4);
        push_tx(8'h43, 4);
        push_tx(8'h44, 4);
        wait_tx_empty(50);
        tick(2);

        // Fill TX while a long pacing interval is running
        out_period = 8'd255;
        push_tx(8'h0F, 0);
        tick();
        for (int i = 0; i < DEPTH; i++)
            push_tx(8'h10 + 8'(i), 0);
        check("full_flag", tx_wfull, 1);
        check("full_count", tx_count, DEPTH);
        check("full_no_ovf", ovf_status, 2'b00);
        tx_winc = 1'b1; tx_wdata = 8'h99;
        tick();
        tx_winc = 1'b0;
        check("drop_count", tx_count, DEPTH);
        check("drop_ovf", ovf_status, 2'b01);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", ovf_status, 2'b00);
        tx_winc = 1'b1; ovf_clr = 1'b1;
        tick();
        tx_winc = 1'b0; ovf_clr = 1'b0;
        check("clr_priority", ovf_status, 2'b00);
        out_period = 8'd0;
        wait_tx_empty(400);
        tick(2);
        check("drain_last", gpio_out, 8'h1F);

        // Pop on empty RX is ignored
        rx_rinc = 1'b1;
        tick();
        rx_rinc = 1'b0;
        check("empty_pop_count", rx_count, 0);
        check("empty_pop_flag", rx_rempty, 1);

        // Input-pin change captured SYNC+1 edges later; output-pin change ignored
        gpio_in = 8'h11;
        tick(SYNC);
        check("cap_not_yet", rx_count, 0);
        tick();
        check("cap_count", rx_count, 1);
        rx_q.push_back(8'h11);
        gpio_in = 8'h01;
        tick(5);
        check("out_pin_ignored", rx_count, 1);
        rx_rinc = 1'b1;
        tick();
        rx_rinc = 1'b0;
        check("cap_popped", rx_rempty, 1);

        // DEPTH+1 captures with no pops: last one dropped
        irq_en = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            gpio_in = 8'(i + 2);
            tick();
        end
        tick(SYNC + 2);
        check("rx_full_count", rx_count, DEPTH);
        check("rx_ovf", ovf_status, 2'b10);
        check("irq_set", irq, 1);
        for (int i = 0; i < DEPTH; i++)
            rx_q.push_back(8'(i + 2));
        rx_rinc = 1'b1;
        tick(DEPTH);
        rx_rinc = 1'b0;
        check("rx_drained_flag", rx_rempty, 1);
        check("rx_drained_count", rx_count, 0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        tick();
        check("rx_ovf_cleared", ovf_status, 2'b00);
        check("irq_clear", irq, 0);

        // Half-fill both FIFOs, then reset between clock edges
        out_period = 8'd255;
        push_tx(8'h55, 0);
        for (int i = 0; i < DEPTH / 2; i++) begin
            gpio_in = 8'h20 + 8'(i);
            push_tx(8'h60 + 8'(i), -1);
        end
        tick(SYNC + 2);
        check("half_tx", tx_count, DEPTH / 2);
        check("half_rx", rx_count, DEPTH / 2);
        check("half_irq", irq, 1);
        #2;
        rrst_n  = 1'b0;
        gpio_in = 8'h05;
        #1;
        check_reset_state("async");
        @(posedge wclk);
        #1;
        rrst_n     = 1'b1;
        out_period = 8'd0;
        tick(SYNC);
        check("post_rst_not_yet", rx_count, 0);
        tick();
        check("post_rst_cap", rx_count, 1);
        rx_q.push_back(8'h05);
        tick(3);
        check("post_rst_single", rx_count, 1);
        rx_rinc = 1'b1;
        tick();
        rx_rinc = 1'b0;
        push_tx(8'h77, 0);
        tick(2);
        check("resume_pin", gpio_out, 8'h77);
        check("resume_count", tx_count, 0);

        tick(3);
        check("tx_queue_left", tx_q.size(), 0);
        check("rx_queue_left", rx_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
